// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Parity modes, TX state encoding and the bit-period divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BREAK,
    ST_MARK
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_frq, input int baud);
    return (clk_frq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered pointers.
// Ports: clk, rst (sync, high), push/wdata in, pop/rdata out, level, full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  // A full FIFO refuses a write even when a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, parity, gapless frames, line break.
// Ports: i_clk, i_rst (sync, high), i_data/i_valid/o_ready write side,
// i_break, o_tx serial line, o_busy, o_level FIFO occupancy.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int I_CLK_FRQ = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int FRAME     = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP      = 1,
  parameter int DEPTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [FRAME-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_break,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int DIV = calc_div(I_CLK_FRQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(FRAME - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  tx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [FRAME-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             tick, load;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [FRAME-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH(FRAME),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (i_valid),
    .pop  (fifo_pop),
    .wdata(i_data),
    .rdata(fifo_rdata),
    .level(o_level),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign tick    = (cnt_q == CNT_LAST);
  assign o_ready = !fifo_full;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_break) state_d = ST_BREAK;
        else if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (tick) state_d = ST_STOP;
      end
      // Stop bits and post-break mark both end by chaining straight
      // into the next queued frame, so there is no idle gap.
      ST_STOP, ST_MARK: begin
        if (tick) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty && !i_break) load = 1'b1;
            else state_d = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        bit_d = '0;
        if (!i_break) state_d = ST_MARK;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      bit_d   = '0;
      sh_d    = fifo_rdata;
      par_d   = (^fifo_rdata) ^ PAR_INV;
    end
    fifo_pop = load;
    // Line level is registered from the next state to keep the pin clean.
    unique case (state_d)
      ST_START, ST_BREAK: tx_d = 1'b0;
      ST_DATA:            tx_d = sh_d[0];
      ST_PAR:             tx_d = par_d;
      default:            tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIV=4.
// Three instances: 8N1 depth 4, 7O2 and 7E2 sharing one write port.
module tb_uart_tx_fifo;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d8;
  logic       v8, brk8, tx8, rdy8, busy8;
  logic [2:0] lvl8;
  logic [6:0] d7;
  logic       v7, brk7;
  logic       txo, rdyo, busyo, txe, rdye, busye;
  logic [2:0] lvlo, lvle;

  int checks = 0;
  int errors = 0;

  logic obs_q[$];
  bit   exp_q[$];

  uart_tx_fifo #(
    .I_CLK_FRQ(1_000_000), .BAUD(250_000), .FRAME(8),
    .PARITY(0), .STOP(1), .DEPTH(4)
  ) u8 (
    .i_clk(clk), .i_rst(rst), .i_data(d8), .i_valid(v8),
    .o_ready(rdy8), .i_break(brk8), .o_tx(tx8),
    .o_busy(busy8), .o_level(lvl8)
  );

  uart_tx_fifo #(
    .I_CLK_FRQ(1_000_000), .BAUD(250_000), .FRAME(7),
    .PARITY(2), .STOP(2), .DEPTH(4)
  ) uo (
    .i_clk(clk), .i_rst(rst), .i_data(d7), .i_valid(v7),
    .o_ready(rdyo), .i_break(brk7), .o_tx(txo),
    .o_busy(busyo), .o_level(lvlo)
  );

  uart_tx_fifo #(
    .I_CLK_FRQ(1_000_000), .BAUD(250_000), .FRAME(7),
    .PARITY(1), .STOP(2), .DEPTH(4)
  ) ue (
    .i_clk(clk), .i_rst(rst), .i_data(d7), .i_valid(v7),
    .o_ready(rdye), .i_break(brk7), .o_tx(txe),
    .o_busy(busye), .o_level(lvle)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, data LSB first, parity, stops.
  function automatic logic [15:0] frame_bits(
    input logic [8:0] w, input int nd, input int par,
    input int ns, output int nb);
    logic [15:0] b;
    logic [8:0]  t;
    int          ones;
    b = '0; nb = 1; ones = 0; t = w;
    for (int i = 0; i < nd; i++) begin
      b = b | (16'(t[0]) << nb);
      ones += int'(t[0]);
      t = t >> 1;
      nb++;
    end
    if (par != 0) begin
      if ((par == 1) == (ones % 2 == 1)) b = b | (16'd1 << nb);
      nb++;
    end
    for (int i = 0; i < ns; i++) begin
      b = b | (16'd1 << nb);
      nb++;
    end
    return b;
  endfunction

  task automatic exp_frame(input logic [8:0] w, input int nd,
                           input int par, input int ns);
    logic [15:0] b;
    int nb;
    b = frame_bits(w, nd, par, ns, nb);
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < DIV; k++) exp_q.push_back(bit'(b[0]));
      b = b >> 1;
    end
  endtask

  task automatic exp_const(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  function automatic int first_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic line(input int which);
    case (which)
      0:       return tx8;
      1:       return txo;
      default: return txe;
    endcase
  endfunction

  // Line receiver: waits for a start edge, then samples every cycle of
  // every bit period; stable=0 if any bit is not held for DIV cycles.
  task automatic rx_frame(input int which, input int nb,
                          output logic [15:0] bits,
                          output bit stable, output int gap);
    logic v;
    gap = 0; stable = 1'b1; bits = '0;
    while (line(which) !== 1'b0) begin
      if (gap >= 3000) begin
        gap = -1;
        return;
      end
      gap++;
      tick();
    end
    for (int b = 0; b < nb; b++) begin
      v = line(which);
      bits = bits | (16'(v) << b);
      for (int k = 0; k < DIV; k++) begin
        if (line(which) !== v) stable = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    checks++;
    if (tx8 !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b want 1", tx8);
    end
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", rdy8);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy8);
    end
    checks++;
    if (lvl8 !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", lvl8);
    end
    checks++;
    if ({txo, rdyo, busyo, lvlo, txe, rdye, busye, lvle} !== 12'b110000110000)
    begin
      errors++;
      $display("FAIL reset_7bit: got %b want 110000110000",
               {txo, rdyo, busyo, lvlo, txe, rdye, busye, lvle});
    end
  endtask

  task automatic test_single();
    int d;
    obs_q.delete(); exp_q.delete();
    exp_const(1'b1, 2);
    exp_frame(9'h0A5, 8, 0, 1);
    exp_const(1'b1, 1);
    for (int i = 0; i < 43; i++) begin
      v8 = (i == 0); d8 = 8'hA5;
      if (i == 1) begin
        checks++;
        if (lvl8 !== 3'd1) begin
          errors++; $display("FAIL single_level: got %0d want 1", lvl8);
        end
      end
      if (i == 41 || i == 42) begin
        checks++;
        if (busy8 !== (i == 41)) begin
          errors++;
          $display("FAIL single_busy cyc %0d: got %b want %b", i, busy8, i == 41);
        end
      end
      obs_q.push_back(tx8);
      tick();
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL single_wave: diff at %0d got %b want %b", d,
               d >= 0 ? obs_q[d] : 1'bx, d >= 0 ? exp_q[d] : 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    int d;
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h55;
    obs_q.delete(); exp_q.delete();
    exp_const(1'b1, 2);
    for (int j = 0; j < 3; j++) exp_frame({1'b0, w[j]}, 8, 0, 1);
    exp_const(1'b1, 1);
    for (int i = 0; i < 123; i++) begin
      v8 = (i < 3);
      d8 = (i < 3) ? w[i] : 8'h00;
      if (i == 1 || i == 2 || i == 3 || i == 42 || i == 82) begin
        checks++;
        if (lvl8 !== ((i == 3) ? 3'd2 : (i == 82) ? 3'd0 : 3'd1)) begin
          errors++;
          $display("FAIL b2b_level cyc %0d: got %0d", i, lvl8);
        end
      end
      obs_q.push_back(tx8);
      tick();
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_end: got %b want 0", busy8);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_wave: diff at %0d got %b want %b", d,
               d >= 0 ? obs_q[d] : 1'bx, d >= 0 ? exp_q[d] : 1'b0);
    end
  endtask

  task automatic test_fill();
    logic [7:0]  w [6];
    logic [7:0]  rxw [6];
    bit          rxok [6];
    logic [7:0]  base;
    int          idx, cyc, rdy_bad;
    bit          saw_full;
    base = 8'($urandom);
    for (int i = 0; i < 6; i++) w[i] = base + 8'(i * 37);
    idx = 0; cyc = 0; rdy_bad = 0; saw_full = 1'b0;
    fork
      begin
        while (idx < 6 && cyc < 500) begin
          v8 = 1'b1; d8 = w[idx];
          if (rdy8 !== (lvl8 != 3'd4)) rdy_bad++;
          if (lvl8 == 3'd4 && rdy8 === 1'b0) saw_full = 1'b1;
          if (rdy8 === 1'b1) idx++;
          tick(); cyc++;
        end
        v8 = 1'b0;
      end
      begin
        logic [15:0] b; bit st; int g;
        for (int j = 0; j < 6; j++) begin
          rx_frame(0, 10, b, st, g);
          rxw[j]  = b[8:1];
          rxok[j] = st && (g >= 0) && (b[0] === 1'b0) && (b[9] === 1'b1);
        end
      end
    join
    checks++;
    if (!saw_full || rdy_bad != 0 || idx != 6) begin
      errors++;
      $display("FAIL fill_ready: full_seen %b ready_errs %0d accepted %0d want 1 0 6",
               saw_full, rdy_bad, idx);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (rxw[j] !== w[j] || !rxok[j]) begin
        errors++;
        $display("FAIL fill_word %0d: got %h ok %b want %h", j, rxw[j], rxok[j], w[j]);
      end
    end
  endtask

  task automatic test_parity();
    logic [15:0] bo, be, want_o, want_e;
    bit so, se;
    int go, ge, nb;
    want_o = frame_bits(9'h003, 7, 2, 2, nb);
    want_e = frame_bits(9'h003, 7, 1, 2, nb);
    fork
      begin d7 = 7'h03; v7 = 1'b1; tick(); v7 = 1'b0; end
      rx_frame(1, 11, bo, so, go);
      rx_frame(2, 11, be, se, ge);
    join
    checks++;
    if (bo !== want_o || !so || go != 2) begin
      errors++;
      $display("FAIL par_odd_frame: got %b st %b gap %0d want %b 1 2", bo, so, go, want_o);
    end
    checks++;
    if (be !== want_e || !se || ge != 2) begin
      errors++;
      $display("FAIL par_even_frame: got %b st %b gap %0d want %b 1 2", be, se, ge, want_e);
    end
    checks++;
    if (bo[8] !== 1'b1 || be[8] !== 1'b0) begin
      errors++;
      $display("FAIL par_bits: odd %b even %b want 1 0", bo[8], be[8]);
    end
    checks++;
    if (busyo !== 1'b0 || busye !== 1'b0 || txo !== 1'b1 || txe !== 1'b1) begin
      errors++;
      $display("FAIL par_len44: busy %b%b tx %b%b want 00 11", busyo, busye, txo, txe);
    end
  endtask

  task automatic test_break();
    int d;
    obs_q.delete(); exp_q.delete();
    exp_const(1'b1, 1);
    exp_const(1'b0, 20);
    exp_const(1'b1, DIV);
    exp_frame(9'h041, 8, 0, 1);
    exp_const(1'b1, 1);
    for (int i = 0; i < 66; i++) begin
      brk8 = (i < 20); v8 = (i == 0); d8 = 8'h41;
      obs_q.push_back(tx8);
      tick();
    end
    d = first_diff();
    checks++;
    if (d != -1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL break_idle: diff at %0d got %b want %b busy %b", d,
               d >= 0 ? obs_q[d] : 1'bx, d >= 0 ? exp_q[d] : 1'b0, busy8);
    end
    obs_q.delete(); exp_q.delete();
    exp_const(1'b1, 2);
    exp_frame(9'h012, 8, 0, 1);
    exp_const(1'b1, 1);
    exp_const(1'b0, 18);
    exp_const(1'b1, 9);
    for (int i = 0; i < 70; i++) begin
      brk8 = (i >= 12 && i < 60); v8 = (i == 0); d8 = 8'h12;
      obs_q.push_back(tx8);
      tick();
    end
    brk8 = 1'b0;
    d = first_diff();
    checks++;
    if (d != -1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL break_midframe: diff at %0d got %b want %b busy %b", d,
               d >= 0 ? obs_q[d] : 1'bx, d >= 0 ? exp_q[d] : 1'b0, busy8);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  w [3];
    logic [15:0] b, want;
    bit st;
    int g, nb;
    w[0] = 8'h00; w[1] = 8'h5A; w[2] = 8'hFF;
    for (int i = 0; i < 13; i++) begin
      v8 = (i < 3);
      d8 = (i < 3) ? w[i] : 8'h00;
      rst = (i == 12);
      if (i == 12) begin
        checks++;
        if (tx8 !== 1'b0) begin
          errors++; $display("FAIL rst_pre_tx: got %b want 0", tx8);
        end
      end
      tick();
    end
    rst = 1'b0;
    checks++;
    if ({tx8, lvl8, busy8, rdy8} !== 6'b100001) begin
      errors++;
      $display("FAIL rst_mid: tx %b lvl %0d busy %b rdy %b want 1 0 0 1",
               tx8, lvl8, busy8, rdy8);
    end
    want = frame_bits(9'h0C3, 8, 0, 1, nb);
    v8 = 1'b1; d8 = 8'hC3;
    tick();
    v8 = 1'b0;
    rx_frame(0, 10, b, st, g);
    checks++;
    if (b !== want || !st || g != 1) begin
      errors++;
      $display("FAIL rst_fresh: got %b st %b gap %0d want %b 1 1", b, st, g, want);
    end
  endtask

  task automatic test_random();
    logic [7:0] sb [$];
    logic [7:0] rxw [20];
    bit         rxok [20];
    int         cyc;
    cyc = 0;
    fork
      begin
        while (sb.size() < 20 && cyc < 5000) begin
          v8 = 1'($urandom_range(0, 1));
          d8 = 8'($urandom);
          if (v8 && rdy8 === 1'b1) sb.push_back(d8);
          tick(); cyc++;
        end
        v8 = 1'b0;
      end
      begin
        logic [15:0] b; bit st; int g;
        for (int j = 0; j < 20; j++) begin
          rx_frame(0, 10, b, st, g);
          rxw[j]  = b[8:1];
          rxok[j] = st && (g >= 0) && (b[0] === 1'b0) && (b[9] === 1'b1);
        end
      end
    join
    checks++;
    if (sb.size() != 20) begin
      errors++; $display("FAIL rand_accept: got %0d want 20", sb.size());
    end
    for (int j = 0; j < 20 && j < sb.size(); j++) begin
      checks++;
      if (rxw[j] !== sb[j] || !rxok[j]) begin
        errors++;
        $display("FAIL rand_word %0d: got %h ok %b want %h", j, rxw[j], rxok[j], sb[j]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    d8 = '0; v8 = 1'b0; brk8 = 1'b0;
    d7 = '0; v7 = 1'b0; brk7 = 1'b0;
    tick();
    tick();
    test_reset();
    tick();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_fill();
    tick();
    test_parity();
    tick();
    test_break();
    tick();
    test_reset_midframe();
    tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
